// File: rtl/calculator.sv
// Eight-entry signed 8-bit stack calculator with a 16-word instruction window.
// Seven-segment display of TOS, depth and error status.
module calculator (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [10:0] inst_w,
  input  logic [2:0]  overflow,
  output logic [3:0]  pc,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [9:0]  LEDR
);

  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_ADD,
    OP_SUB, OP_MUL, OP_NEG, OP_HALT
  } op_e;

  logic [3:0]        pc_q, pc_d;
  logic [3:0]        depth_q, depth_d;
  logic signed [7:0] stack_q [8];
  logic signed [7:0] stack_d [8];
  logic              ovf_q, ovf_d;
  logic              serr_q, serr_d;
  logic              halt_q, halt_d;

  op_e                op;
  logic [2:0]         tos_i, nos_i;
  logic signed [16:0] a_w, b_w, wide;
  logic signed [7:0]  res;
  logic               is_bin, arith, stk_err, ovf_now;

  always_comb begin
    op    = op_e'(inst_w[10:8]);
    tos_i = depth_q[2:0] - 3'd1;
    nos_i = depth_q[2:0] - 3'd2;
    a_w   = stack_q[nos_i];
    b_w   = stack_q[tos_i];
    is_bin = (op == OP_ADD) || (op == OP_SUB)
          || (op == OP_MUL);
    arith = is_bin || (op == OP_NEG);
    stk_err = ((op == OP_PUSH) && (depth_q == 4'd8))
           || (((op == OP_POP) || (op == OP_NEG))
               && (depth_q == 4'd0))
           || (is_bin && (depth_q < 4'd2));
    unique case (op)
      OP_ADD:  wide = a_w + b_w;
      OP_SUB:  wide = a_w - b_w;
      OP_MUL:  wide = a_w * b_w;
      default: wide = -b_w;
    endcase
    ovf_now = arith && !stk_err
           && ((wide > 17'sd127) || (wide < -17'sd128));
    res = wide[7:0];
    if (ovf_now && overflow[0])
      res = (wide > 17'sd0) ? 8'sd127 : -8'sd128;
  end

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    stack_d = stack_q;
    ovf_d   = ovf_q;
    serr_d  = serr_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      pc_d = pc_q + 4'd1;
      if (stk_err) begin
        serr_d = 1'b1;
        if (overflow[2]) halt_d = 1'b1;
      end else begin
        unique case (op)
          OP_PUSH: begin
            stack_d[depth_q[2:0]] = inst_w[7:0];
            depth_d = depth_q + 4'd1;
          end
          OP_POP: depth_d = depth_q - 4'd1;
          OP_ADD, OP_SUB, OP_MUL: begin
            stack_d[nos_i] = res;
            depth_d = depth_q - 4'd1;
          end
          OP_NEG:  stack_d[tos_i] = res;
          OP_HALT: halt_d = 1'b1;
          OP_NOP:  ;
        endcase
        if (ovf_now) begin
          ovf_d = 1'b1;
          if (overflow[1]) halt_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      stack_q <= stack_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
      halt_q  <= halt_d;
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  logic [7:0] disp, mag;
  logic [3:0] hund, tens, ones;

  // Magnitude fits 8 bits unsigned, including 128 for -128.
  always_comb begin
    disp = (depth_q == 4'd0) ? 8'd0 : stack_q[tos_i];
    mag  = disp[7] ? (~disp + 8'd1) : disp;
    hund = 4'(mag / 8'd100);
    tens = 4'((mag / 8'd10) % 8'd10);
    ones = 4'(mag % 8'd10);
    HEX0 = seg(ones);
    HEX1 = ((hund == 4'd0) && (tens == 4'd0)) ? 7'h7F : seg(tens);
    HEX2 = (hund == 4'd0) ? 7'h7F : seg(hund);
    HEX3 = disp[7] ? 7'h3F : 7'h7F;
    HEX4 = seg(depth_q);
    HEX5 = serr_q ? 7'h06 : 7'h7F;
    LEDR = {halt_q, ovf_q, disp};
    pc   = pc_q;
  end

endmodule

// File: tb/tb_calculator.sv
// Directed table-driven bench for the stack calculator.
// Each row is one clock of stimulus followed by an output check.
module tb_calculator;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] inst_w = '0;
  logic [2:0]  overflow = '0;
  logic [3:0]  pc;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0]  LEDR;

  calculator dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .inst_w(inst_w),
    .overflow(overflow), .pc(pc),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5), .LEDR(LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24;
  localparam logic [6:0] D3 = 7'h30, D5 = 7'h12;
  localparam logic [6:0] D6 = 7'h02, D7 = 7'h78, D8 = 7'h00;
  localparam logic [6:0] D9 = 7'h10, BL = 7'h7F;
  localparam logic [6:0] MN = 7'h3F, EE = 7'h06;

  localparam logic [2:0] NOP = 3'd0, PSH = 3'd1, POP = 3'd2;
  localparam logic [2:0] ADD = 3'd3, SUB = 3'd4, MUL = 3'd5;
  localparam logic [2:0] NEG = 3'd6, HLT = 3'd7;

  typedef struct {
    logic        rst;
    logic [10:0] inst;
    logic [2:0]  ovf;
    logic [3:0]  pc;
    logic [9:0]  ledr;
    logic [41:0] hex;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [10:0] ins(
    input logic [2:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  task automatic add_v(
    input logic rst, input logic [10:0] inst,
    input logic [2:0] ovf, input logic [3:0] epc,
    input logic [9:0] eled,
    input logic [6:0] h5, input logic [6:0] h4,
    input logic [6:0] h3, input logic [6:0] h2,
    input logic [6:0] h1, input logic [6:0] h0);
    vec_t v;
    v.rst = rst; v.inst = inst; v.ovf = ovf;
    v.pc = epc; v.ledr = eled;
    v.hex = {h5, h4, h3, h2, h1, h0};
    vecs.push_back(v);
  endtask

  task automatic chk(
    input string nm, input logic [63:0] got,
    input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step(
    input logic rst, input logic [10:0] inst,
    input logic [2:0] ovf);
    reset = rst; inst_w = inst; overflow = ovf;
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [41:0] hexv();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return D0; 1: return D1; 2: return D2;
      3: return D3; 5: return D5; 6: return D6;
      7: return D7; 8: return D8; 9: return D9;
      default: return 7'h19;
    endcase
  endfunction

  initial begin
    // reset state
    add_v(1, ins(NOP,0), 0, 0, 10'h000, BL,D0,BL,BL,BL,D0);
    // 5 + 7
    add_v(0, ins(PSH,5), 0, 1, 10'h005, BL,D1,BL,BL,BL,D5);
    add_v(0, ins(PSH,7), 0, 2, 10'h007, BL,D2,BL,BL,BL,D7);
    add_v(0, ins(ADD,0), 0, 3, 10'h00C, BL,D1,BL,BL,D1,D2);
    // 5 - 7
    add_v(1, ins(NOP,0), 0, 0, 10'h000, BL,D0,BL,BL,BL,D0);
    add_v(0, ins(PSH,5), 0, 1, 10'h005, BL,D1,BL,BL,BL,D5);
    add_v(0, ins(PSH,7), 0, 2, 10'h007, BL,D2,BL,BL,BL,D7);
    add_v(0, ins(SUB,0), 0, 3, 10'h0FE, BL,D1,MN,BL,BL,D2);
    // 100 + 100 wrap
    add_v(1, ins(NOP,0), 0, 0, 10'h000, BL,D0,BL,BL,BL,D0);
    add_v(0, ins(PSH,100), 0, 1, 10'h064, BL,D1,BL,D1,D0,D0);
    add_v(0, ins(PSH,100), 0, 2, 10'h064, BL,D2,BL,D1,D0,D0);
    add_v(0, ins(ADD,0), 0, 3, 10'h1C8, BL,D1,MN,BL,D5,D6);
    // 100 + 100 saturate
    add_v(1, ins(NOP,0), 0, 0, 10'h000, BL,D0,BL,BL,BL,D0);
    add_v(0, ins(PSH,100), 1, 1, 10'h064, BL,D1,BL,D1,D0,D0);
    add_v(0, ins(PSH,100), 1, 2, 10'h064, BL,D2,BL,D1,D0,D0);
    add_v(0, ins(ADD,0), 1, 3, 10'h17F, BL,D1,BL,D1,D2,D7);
    // -127 - 1 = -128, then NEG overflow, then MUL stack error
    add_v(1, ins(NOP,0), 0, 0, 10'h000, BL,D0,BL,BL,BL,D0);
    add_v(0, ins(PSH,127), 0, 1, 10'h07F, BL,D1,BL,D1,D2,D7);
    add_v(0, ins(NEG,0), 0, 2, 10'h081, BL,D1,MN,D1,D2,D7);
    add_v(0, ins(PSH,1), 0, 3, 10'h001, BL,D2,BL,BL,BL,D1);
    add_v(0, ins(SUB,0), 0, 4, 10'h080, BL,D1,MN,D1,D2,D8);
    add_v(0, ins(NEG,0), 0, 5, 10'h180, BL,D1,MN,D1,D2,D8);
    add_v(0, ins(MUL,0), 0, 6, 10'h180, EE,D1,MN,D1,D2,D8);
    // binary op at depth 0, no halt
    add_v(1, ins(NOP,0), 0, 0, 10'h000, BL,D0,BL,BL,BL,D0);
    add_v(0, ins(ADD,0), 0, 1, 10'h000, EE,D0,BL,BL,BL,D0);
    // same with halt on stack error; later inputs ignored
    add_v(1, ins(NOP,0), 0, 0, 10'h000, BL,D0,BL,BL,BL,D0);
    add_v(0, ins(ADD,0), 4, 1, 10'h200, EE,D0,BL,BL,BL,D0);
    add_v(0, ins(PSH,5), 0, 1, 10'h200, EE,D0,BL,BL,BL,D0);
    add_v(0, ins(NOP,0), 0, 1, 10'h200, EE,D0,BL,BL,BL,D0);
    // reset while halted, then MUL and saturating halt
    add_v(1, ins(NOP,0), 0, 0, 10'h000, BL,D0,BL,BL,BL,D0);
    add_v(0, ins(PSH,8'hFD), 0, 1, 10'h0FD, BL,D1,MN,BL,BL,D3);
    add_v(0, ins(PSH,20), 0, 2, 10'h014, BL,D2,BL,BL,D2,D0);
    add_v(0, ins(MUL,0), 2, 3, 10'h0C4, BL,D1,MN,BL,D6,D0);
    add_v(0, ins(PSH,10), 0, 4, 10'h00A, BL,D2,BL,BL,D1,D0);
    add_v(0, ins(MUL,0), 3, 5, 10'h380, BL,D1,MN,D1,D2,D8);
    add_v(0, ins(NOP,0), 0, 5, 10'h380, BL,D1,MN,D1,D2,D8);
    add_v(0, ins(POP,0), 0, 5, 10'h380, BL,D1,MN,D1,D2,D8);
    // POP at depth 0, sticky error flag
    add_v(1, ins(NOP,0), 0, 0, 10'h000, BL,D0,BL,BL,BL,D0);
    add_v(0, ins(POP,0), 0, 1, 10'h000, EE,D0,BL,BL,BL,D0);
    add_v(0, ins(PSH,9), 0, 2, 10'h009, EE,D1,BL,BL,BL,D9);
    add_v(0, ins(POP,0), 0, 3, 10'h000, EE,D0,BL,BL,BL,D0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].inst, vecs[i].ovf);
      chk($sformatf("row%0d_pc", i), 64'(pc), 64'(vecs[i].pc));
      chk($sformatf("row%0d_ledr", i), 64'(LEDR),
          64'(vecs[i].ledr));
      chk($sformatf("row%0d_hex", i), 64'(hexv()),
          64'(vecs[i].hex));
    end

    // 17 NOPs: pc wraps 15 -> 0
    step(1, ins(NOP,0), 0);
    chk("nop_reset_pc", 64'(pc), 64'd0);
    for (int k = 1; k <= 17; k++) begin
      step(0, ins(NOP,0), 0);
      chk($sformatf("nop%0d_pc", k), 64'(pc), 64'(k % 16));
    end
    chk("nop_ledr", 64'(LEDR), 64'd0);
    chk("nop_hex5", 64'(HEX5), 64'(BL));

    // nine pushes: ninth overflows the stack
    step(1, ins(NOP,0), 0);
    for (int k = 1; k <= 9; k++) begin
      step(0, ins(PSH, 8'(k)), 0);
      chk($sformatf("push%0d_depth", k), 64'(HEX4),
          64'(dig(k > 8 ? 8 : k)));
      chk($sformatf("push%0d_hex5", k), 64'(HEX5),
          64'(k == 9 ? EE : BL));
    end
    chk("push9_tos", 64'(LEDR), 64'h008);
    chk("push9_pc", 64'(pc), 64'd9);
    step(0, ins(HLT,0), 0);
    chk("halt_pc", 64'(pc), 64'd10);
    chk("halt_ledr", 64'(LEDR), 64'h208);
    for (int k = 0; k < 3; k++) begin
      step(0, ins(PSH,1), 0);
      chk($sformatf("halted%0d_pc", k), 64'(pc), 64'd10);
      chk($sformatf("halted%0d_ledr", k), 64'(LEDR), 64'h208);
    end
    step(1, ins(NOP,0), 0);
    chk("final_pc", 64'(pc), 64'd0);
    chk("final_ledr", 64'(LEDR), 64'd0);
    chk("final_hex", 64'(hexv()),
        64'({BL, D0, BL, BL, BL, D0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/calculator.md
CALCULATOR -- requirements
Module: calculator

Interface
REQ-001 The module SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 CLOCK_50  input  1  rising-edge clock; all state SHALL change only on this edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_w  input  11  instruction at address pc: [10:8] opcode, [7:0] signed immediate. The instruction source is combinational, so inst_w is valid in the same cycle as pc.
REQ-005 overflow  input  3  policy bits: [0] saturate (1) or wrap (0) on arithmetic overflow; [1] halt on arithmetic overflow; [2] halt on stack error.
REQ-006 pc  output  4  registered program counter (instruction address).
REQ-007 HEX0..HEX5  output  7 each  active-low seven-segment digits, bit6 = g … bit0 = a.
REQ-008 LEDR  output  10  [7:0] top of stack (TOS) raw; [8] sticky arithmetic-overflow flag; [9] halted.

Function
REQ-009 The module SHALL execute one instruction per clock cycle while not halted, then set pc to pc+1, wrapping from 15 to 0.
REQ-010 The stack SHALL hold 8 entries of signed 8-bit values, with a depth counter from 0 to 8.
REQ-011 Opcodes SHALL be:
- 000 NOP.
- 001 PUSH imm.
- 010 POP.
- 011 ADD.
- 100 SUB.
- 101 MUL.
- 110 NEG.
- 111 HALT.
REQ-012 Each binary op SHALL pop B (TOS) and then A, and push the result of A op B, so depth decreases by 1.
- SUB computes A−B.
- MUL takes the full product.
REQ-013 NEG SHALL replace TOS with −TOS.
REQ-014 Arithmetic SHALL be computed at full width. A result outside −128..127 is an arithmetic overflow; it SHALL:
- store the saturated value if overflow[0]=1, otherwise the low 8 bits;
- set LEDR[8].
REQ-015 Stack errors SHALL leave stack and depth unchanged and set a sticky stack-error flag. The cases are:
- PUSH at depth 8;
- POP or NEG at depth 0;
- a binary op at depth <2.
REQ-016 HALT SHALL set the halted flag. While halted:
- pc holds;
- the stack is frozen;
- inst_w is ignored until reset.
REQ-017 An arithmetic overflow with overflow[1]=1 SHALL write the result and set halted in the same cycle. pc SHALL still advance once in that cycle.
REQ-018 A stack error with overflow[2]=1 SHALL set halted in the same cycle. pc SHALL still advance once in that cycle.
REQ-019 overflow SHALL be sampled in the cycle of the executing instruction.
REQ-020 The display value SHALL be TOS, or 0 when depth is 0.
- HEX2..HEX0 show the decimal magnitude 0..128.
- HEX2 and HEX1 suppress leading zeros (blank); HEX0 is always lit.
- HEX3 shows minus (7'h3F) if the value is negative, otherwise blank.
- HEX4 shows the depth digit 0..8.
- HEX5 shows 'E' (7'h06) if the stack-error flag is set, otherwise blank.
REQ-021 The digit encodings SHALL be:

| Digit | Code |
|---|---|
| 0 | 40 |
| 1 | 79 |
| 2 | 24 |
| 3 | 30 |
| 4 | 19 |
| 5 | 12 |
| 6 | 02 |
| 7 | 78 |
| 8 | 00 |
| 9 | 10 |
| blank | 7F |

REQ-022 Display outputs and LEDR SHALL be combinational from the registered state, so they reflect an instruction's effect in the cycle after its clock edge.

Reset
REQ-023 reset SHALL take priority over execution, including while halted and in mid-program. On reset:
- pc = 0;
- depth = 0;
- stack contents are don't-care but not displayed;
- all flags are clear;
- halted = 0.
REQ-024 Outputs after reset SHALL be:
- LEDR = 0;
- HEX0 = 7'h40;
- HEX4 = 7'h40;
- HEX1, HEX2, HEX3 and HEX5 = 7'h7F.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Reset, then NOPs for 17 cycles → pc counts 0..15, 0, 1; no flags set.
- PUSH 5, PUSH 7, ADD → TOS 12, depth 1, HEX1=79, HEX0=24; SUB of 5−7 instead → −2 shown with HEX3=3F.
- PUSH 100, PUSH 100, ADD, overflow=000 → TOS −56, LEDR[8]=1; same with overflow=001 → TOS 127.
- PUSH 127, NEG, PUSH 1, SUB → TOS −128; display HEX2..0 = 1,2,8 with minus.
- ADD at depth 0 → HEX5=06, depth 0, pc advances; with overflow=100 → LEDR[9]=1 and pc frozen at 1.
- Nine PUSHes → ninth is an error and depth stays 8; HALT → pc frozen; reset → pc 0, LEDR 0.
